pulse_event_scheduler: RTL and testbench
========================================

# pulse_event_scheduler

Sending-side scheduler for the two-phase CDC pulse synchronizer. It collects single-cycle events from up to REQUESTERS sources and counts them per source, saturating. It then issues them one at a time, in round-robin order, as single-cycle pulses with a source index. Each pulse is followed by an enforced gap of MIN_GAP cycles, so consecutive toggles cannot outrun the receiving-domain synchronizer and edge detector. The synchronizer has no ready/acknowledge path, so this block is the only thing preventing lost or merged pulses.

## Interface
- REQUESTERS, 4: number of event sources; must be ≥2.
- COUNT_WIDTH, 4: per-source pending-count width; maximum count is 2^COUNT_WIDTH−1.
- MIN_GAP, 4: idle cycles after each issued pulse before the next can issue. Must be ≥2. Sized by the integrator as ≥ (receiving synchronizer depth + 2) × ceil(receiving period / sending period).
- INDEX_WIDTH is a localparam, equal to max(1, clog2(REQUESTERS)).

Ports:
- clock  in  1  sending-domain clock; all logic is on its rising edge.
- clear  in  1  synchronous, active-high reset.
- enable  in  1  when low, no new issue begins; counting continues.
- request_in  in  REQUESTERS  each bit high for one cycle = one event; high for K cycles = K events.
- overflow_clear  in  REQUESTERS  clears the matching sticky overflow bit.
- pulse_out  out  1  one-cycle pulse; connects to the synchronizer's sending_pulse_in.
- pulse_index  out  INDEX_WIDTH  source of the current pulse; valid only while pulse_out=1, 0 otherwise.
- pending_out  out  REQUESTERS  bit i = count[i] ≠ 0.
- overflow_out  out  REQUESTERS  sticky; set when an event is dropped at saturation.
- busy  out  1  high in ISSUE or GAP.

## Operation
- **Reset (clear=1):** all counts = 0; overflow = 0; round-robin pointer = 0; state = IDLE; gap counter = 0.
  - All outputs are 0 in the cycle after clear.
  - clear overrides every other input, including mid-ISSUE or mid-GAP. A pulse already in flight is abandoned; the synchronizer state is not touched.
- **Per-source counter update:**
  - Increment when request_in[i]=1.
  - Decrement when the FSM is in ISSUE with grant = i.
  - Increment and decrement together: count unchanged.
  - Increment at max without decrement: count holds and overflow_out[i] is set.
  - At max with both increment and decrement: count stays at max; no overflow.
- **Overflow bits:** overflow_clear[i] clears bit i. If set and clear happen in the same cycle, set wins.
- **FSM states: IDLE, ISSUE, GAP.**
  - IDLE: if enable=1 and any pending bit is set, register grant = the first pending index at or after the pointer (wrapping), then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: lasts exactly one cycle.
    - pulse_out=1 and pulse_index=grant.
    - The count for the grant is decremented.
    - pointer becomes (grant+1) mod REQUESTERS.
    - The gap counter loads MIN_GAP−1; next state is GAP.
  - GAP: the gap counter decrements each cycle; when it reaches 0, go to IDLE.
- enable=0 while in ISSUE or GAP does not abort the sequence; it only blocks the next grant in IDLE.
- The pointer advances only on issue, so every pending source is served within REQUESTERS issues.

## Timing
- pulse_out and pulse_index are registered (state-decoded from registers); no combinational path runs from any input to any output.
- Latency: request_in high in cycle t → pending_out high in t+1 → pulse_out high in t+2 (FSM idle, enable=1).
- Minimum spacing between pulse_out rising edges is MIN_GAP+2 cycles: ISSUE (1) + GAP (MIN_GAP) + IDLE (1).
  - pulse_out is therefore never high in consecutive cycles, which keeps the synchronizer's input edge detector valid.
- pending_out and overflow_out reflect the registered state, one cycle after the causing event.
- A continuously asserted source saturates, because arrival rate (1 per cycle) exceeds issue rate; overflow is then expected and is set.

## Structure
- Package pulse_event_scheduler_pkg holds:
  - the state enum (IDLE, ISSUE, GAP), as a 2-bit typedef;
  - a function computing INDEX_WIDTH.
- One sub-module, pulse_event_counter: a saturating up/down counter with sticky overflow, parameterized on COUNT_WIDTH, instantiated REQUESTERS times.
- The round-robin pick and the FSM live in the top level.

## Test plan
- **Reset:** clear for 2 cycles with request_in=4'b1111 → all counts, pulse_out, overflow_out and busy are 0; pointer is 0.
- **Single event:** one pulse on request_in[2] in cycle 10.
  - pending_out=4'b0100 in cycle 11.
  - pulse_out=1 with pulse_index=2 in cycle 12 only.
  - busy high in cycles 12–16 (MIN_GAP=4); pending_out=0 from cycle 13.
- **Round robin:** a single-cycle request_in=4'b1011 → pulses with indices 0, 1, 3, each separated by MIN_GAP+2=6 cycles, then idle.
- **Saturation:** hold request_in[0] for 20 cycles with enable=0.
  - count reaches 15; overflow_out[0]=1 from the cycle after the 16th event.
  - Then enable=1 with no requests → exactly 15 pulses with index 0.
  - overflow_clear[0] drops overflow_out[0].
- **Simultaneous increment and decrement:** request_in[1] high in the ISSUE cycle granting 1, with count 1 → count stays 1, and a second pulse with index 1 follows after the gap.
- **enable/clear mid-operation:**
  - enable deasserted in a GAP cycle → the gap completes and no new pulse issues until enable returns.
  - clear asserted during GAP → next cycle is IDLE with all state zeroed.

Source files
------------

// File: rtl/pulse_event_scheduler_pkg.sv
// Shared types and sizing helpers for the pulse event scheduler.
package pulse_event_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } sched_state_e;

    function automatic int index_width(input int requesters);
        return (requesters > 2) ? $clog2(requesters) : 1;
    endfunction

endpackage

// File: rtl/pulse_event_counter.sv
// Saturating up/down event counter with a sticky overflow flag.
module pulse_event_counter #(
    parameter int COUNT_WIDTH = 4
) (
    input  logic clock,
    input  logic clear,
    input  logic inc_i,
    input  logic dec_i,
    input  logic overflow_clear_i,
    output logic pending_o,
    output logic overflow_o
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   ovf_set;

    always_comb begin
        count_d = count_q;
        ovf_set = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == COUNT_MAX) begin
                ovf_set = 1'b1;
            end else begin
                count_d = count_q + COUNT_WIDTH'(1);
            end
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - COUNT_WIDTH'(1);
        end
        // A drop in the same cycle as a clear request must still be reported.
        overflow_d = ovf_set | (overflow_q & ~overflow_clear_i);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending_o  = (count_q != '0);
    assign overflow_o = overflow_q;

endmodule

// File: rtl/pulse_event_scheduler.sv
// Round-robin scheduler that issues counted events as spaced single-cycle pulses.
//   state | meaning
//   IDLE  | waiting for enable and a pending source; latches the grant
//   ISSUE | one-cycle pulse for the grant, its count is consumed
//   GAP   | MIN_GAP quiet cycles so the receiving synchronizer keeps up
module pulse_event_scheduler
    import pulse_event_scheduler_pkg::*;
#(
    parameter int REQUESTERS  = 4,
    parameter int COUNT_WIDTH = 4,
    parameter int MIN_GAP     = 4,
    localparam int INDEX_WIDTH = index_width(REQUESTERS)
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [REQUESTERS-1:0]  request_in,
    input  logic [REQUESTERS-1:0]  overflow_clear,
    output logic                   pulse_out,
    output logic [INDEX_WIDTH-1:0] pulse_index,
    output logic [REQUESTERS-1:0]  pending_out,
    output logic [REQUESTERS-1:0]  overflow_out,
    output logic                   busy
);

    localparam int GAP_WIDTH = $clog2(MIN_GAP);
    localparam logic [GAP_WIDTH-1:0]   GAP_LOAD = GAP_WIDTH'(MIN_GAP - 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(REQUESTERS - 1);

    sched_state_e           state_q, state_d;
    logic [INDEX_WIDTH-1:0] grant_q, grant_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic [GAP_WIDTH-1:0]   gap_q, gap_d;

    logic [REQUESTERS-1:0]  dec;
    logic                   pick_found;
    logic [INDEX_WIDTH-1:0] pick_idx;
    logic [INDEX_WIDTH-1:0] cand_idx;
    int                     cand;

    for (genvar i = 0; i < REQUESTERS; i++) begin : g_cnt
        pulse_event_counter #(
            .COUNT_WIDTH(COUNT_WIDTH)
        ) u_cnt (
            .clock           (clock),
            .clear           (clear),
            .inc_i           (request_in[i]),
            .dec_i           (dec[i]),
            .overflow_clear_i(overflow_clear[i]),
            .pending_o       (pending_out[i]),
            .overflow_o      (overflow_out[i])
        );
    end

    always_comb begin
        dec = '0;
        if (state_q == ST_ISSUE) begin
            dec[grant_q] = 1'b1;
        end
    end

    // First pending source at or after the pointer, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            cand     = (int'(ptr_q) + k) % REQUESTERS;
            cand_idx = INDEX_WIDTH'(cand);
            if (!pick_found && pending_out[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + INDEX_WIDTH'(1);
                gap_d   = GAP_LOAD;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
        end
    end

    assign pulse_out   = (state_q == ST_ISSUE);
    assign pulse_index = pulse_out ? grant_q : '0;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pulse_event_scheduler.sv
// Directed bench for pulse_event_scheduler with a cycle-numbered reference model.
module tb_pulse_event_scheduler;

    localparam int R  = 4;
    localparam int CW = 4;
    localparam int MG = 4;
    localparam int IW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          clear;
    logic          enable;
    logic [R-1:0]  request_in;
    logic [R-1:0]  overflow_clear;
    logic          pulse_out;
    logic [IW-1:0] pulse_index;
    logic [R-1:0]  pending_out;
    logic [R-1:0]  overflow_out;
    logic          busy;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: counts per source, plus the cycle number of the most recent pulse.
    int m_cnt [R];
    bit m_ovf [R];
    int m_ptr       = 0;
    bit m_has_pulse = 1'b0;
    int m_last      = 0;
    int m_grant     = 0;

    pulse_event_scheduler #(
        .REQUESTERS (R),
        .COUNT_WIDTH(CW),
        .MIN_GAP    (MG)
    ) dut (
        .clock         (clock),
        .clear         (clear),
        .enable        (enable),
        .request_in    (request_in),
        .overflow_clear(overflow_clear),
        .pulse_out     (pulse_out),
        .pulse_index   (pulse_index),
        .pending_out   (pending_out),
        .overflow_out  (overflow_out),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    always @(posedge clock) begin
        bit prev_busy, prev_pulse, inc, dec;
        int g, c;
        cyc = cyc + 1;
        if (clear) begin
            for (int i = 0; i < R; i++) begin
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
            end
            m_ptr = 0;
            m_has_pulse = 1'b0;
            m_last = 0;
            m_grant = 0;
        end else begin
            prev_busy  = m_has_pulse && ((cyc - 1 - m_last) <= MG);
            prev_pulse = m_has_pulse && ((cyc - 1) == m_last);
            g = -1;
            if (enable && !prev_busy) begin
                for (int k = 0; k < R; k++) begin
                    c = (m_ptr + k) % R;
                    if (g < 0 && m_cnt[c] > 0) g = c;
                end
            end
            for (int i = 0; i < R; i++) begin
                inc = request_in[i];
                dec = prev_pulse && (m_grant == i);
                if (inc && !dec) begin
                    if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
                    else m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] != CMAX && overflow_clear[i]) m_ovf[i] = m_ovf[i];
                end else if (dec && !inc && m_cnt[i] > 0) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
                if (overflow_clear[i] && !(inc && !dec && m_cnt[i] == CMAX && m_ovf[i] && (m_cnt[i] == CMAX)))
                    m_ovf[i] = 1'b0;
            end
            if (g >= 0) begin
                m_has_pulse = 1'b1;
                m_last = cyc;
                m_grant = g;
                m_ptr = (g + 1) % R;
            end
        end
    end

    always @(negedge clock) begin
        logic [R-1:0] e_pend, e_ovf;
        bit e_pulse, e_busy;
        int e_idx;
        if (cyc >= 1) begin
            for (int i = 0; i < R; i++) begin
                e_pend[i] = (m_cnt[i] != 0);
                e_ovf[i]  = m_ovf[i];
            end
            e_pulse = m_has_pulse && (cyc == m_last);
            e_busy  = m_has_pulse && ((cyc - m_last) <= MG);
            e_idx   = e_pulse ? m_grant : 0;
            check("model pulse_out", 32'(pulse_out), 32'(e_pulse));
            check("model pulse_index", 32'(pulse_index), 32'(e_idx));
            check("model pending_out", 32'(pending_out), 32'(e_pend));
            check("model overflow_out", 32'(overflow_out), 32'(e_ovf));
            check("model busy", 32'(busy), 32'(e_busy));
        end
    end

    initial begin
        int pulses;
        int idx_bad;
        clear = 1'b1;
        enable = 1'b1;
        request_in = 4'b1111;
        overflow_clear = '0;

        // Reset held with every request asserted.
        step(2);
        check("reset pulse_out", 32'(pulse_out), 32'd0);
        check("reset pending", 32'(pending_out), 32'd0);
        check("reset overflow", 32'(overflow_out), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        clear = 1'b0;
        request_in = '0;
        step(1);
        check("post-reset pending", 32'(pending_out), 32'd0);

        // Single event on source 2.
        step(7);
        request_in = 4'b0100;
        step(1);
        request_in = '0;
        check("single pending", 32'(pending_out), 32'b0100);
        check("single no early pulse", 32'(pulse_out), 32'd0);
        step(1);
        check("single pulse", 32'(pulse_out), 32'd1);
        check("single index", 32'(pulse_index), 32'd2);
        check("single busy issue", 32'(busy), 32'd1);
        step(1);
        check("single pulse drop", 32'(pulse_out), 32'd0);
        check("single pending drop", 32'(pending_out), 32'd0);
        step(3);
        check("single busy last gap", 32'(busy), 32'd1);
        step(1);
        check("single idle", 32'(busy), 32'd0);

        // Round robin from a freshly cleared pointer.
        do_clear();
        request_in = 4'b1011;
        step(1);
        request_in = '0;
        step(1);
        check("rr first pulse", 32'(pulse_out), 32'd1);
        check("rr first index", 32'(pulse_index), 32'd0);
        step(6);
        check("rr second pulse", 32'(pulse_out), 32'd1);
        check("rr second index", 32'(pulse_index), 32'd1);
        step(6);
        check("rr third pulse", 32'(pulse_out), 32'd1);
        check("rr third index", 32'(pulse_index), 32'd3);
        step(6);
        check("rr done pulse", 32'(pulse_out), 32'd0);
        check("rr done busy", 32'(busy), 32'd0);

        // Saturation with issue held off.
        do_clear();
        enable = 1'b0;
        request_in = 4'b0001;
        step(15);
        check("sat no overflow at 15", 32'(overflow_out), 32'd0);
        step(1);
        check("sat overflow at 16", 32'(overflow_out), 32'b0001);
        step(4);
        request_in = '0;
        enable = 1'b1;
        pulses = 0;
        idx_bad = 0;
        for (int i = 0; i < 110; i++) begin
            step(1);
            if (pulse_out === 1'b1) begin
                pulses++;
                if (pulse_index !== 2'd0) idx_bad++;
            end
        end
        check("sat pulse count", 32'(pulses), 32'd15);
        check("sat index errors", 32'(idx_bad), 32'd0);
        check("sat drained", 32'(pending_out), 32'd0);
        check("sat overflow sticky", 32'(overflow_out), 32'b0001);
        overflow_clear = 4'b0001;
        step(1);
        overflow_clear = '0;
        check("sat overflow cleared", 32'(overflow_out), 32'd0);

        // Increment and decrement in the same ISSUE cycle.
        do_clear();
        request_in = 4'b0010;
        step(1);
        request_in = '0;
        step(1);
        check("incdec first pulse", 32'(pulse_out), 32'd1);
        check("incdec first index", 32'(pulse_index), 32'd1);
        request_in = 4'b0010;
        step(1);
        request_in = '0;
        check("incdec count held", 32'(pending_out), 32'b0010);
        step(5);
        check("incdec second pulse", 32'(pulse_out), 32'd1);
        check("incdec second index", 32'(pulse_index), 32'd1);
        step(1);
        check("incdec drained", 32'(pending_out), 32'd0);

        // enable dropped during GAP.
        do_clear();
        request_in = 4'b0011;
        step(1);
        request_in = '0;
        step(1);
        check("en first index", 32'(pulse_index), 32'd0);
        step(1);
        enable = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (pulse_out === 1'b1) pulses++;
        end
        check("en held no pulses", 32'(pulses), 32'd0);
        check("en held idle", 32'(busy), 32'd0);
        check("en held pending", 32'(pending_out), 32'b0010);
        enable = 1'b1;
        step(1);
        check("en resume pulse", 32'(pulse_out), 32'd1);
        check("en resume index", 32'(pulse_index), 32'd1);

        // clear during GAP.
        do_clear();
        request_in = 4'b1100;
        step(1);
        request_in = '0;
        step(1);
        check("clr pulse index", 32'(pulse_index), 32'd2);
        step(2);
        check("clr in gap", 32'(busy), 32'd1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clr busy", 32'(busy), 32'd0);
        check("clr pulse", 32'(pulse_out), 32'd0);
        check("clr pending", 32'(pending_out), 32'd0);
        check("clr overflow", 32'(overflow_out), 32'd0);
        step(3);
        check("clr stays idle", 32'(pulse_out), 32'd0);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
